// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee: FSM states and
// active-low seven-segment patterns (segment order gfedcba, bit 6 = g).
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } referee_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGITS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/tug_referee_if.sv
// Player/playfield bundle seen by the referee. The referee takes the slave
// side; the playfield/player logic takes the master side.
interface tug_referee_if #(
  parameter int SCORE_W = 3
);
  // L and R are single-cycle press pulses, already synchronised upstream.
  // There is no valid/ready handshake: every sampled input is acted on at
  // the next clk edge, and outputs are registered.
  logic               L;
  logic               R;
  logic               left_end;
  logic               right_end;
  logic               game_over;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic               match_over;
  logic               winner;
  logic [6:0]         hex_left;
  logic [6:0]         hex_right;

  modport master (
    output L, R, left_end, right_end,
    input  game_over, left_score, right_score, match_over, winner,
           hex_left, hex_right
  );

  modport slave (
    input  L, R, left_end, right_end,
    output game_over, left_score, right_score, match_over, winner,
           hex_left, hex_right
  );
endinterface

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment pattern.
module seg7_decode
  import tug_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_DIGITS[digit_i];

endmodule

// File: rtl/tug_referee.sv
// Round/match referee for the tug-of-war playfield: scores round wins, drives
// game_over back to the lights, declares the winner. TUG_HEX_EN enables the
// seven-segment score digits; otherwise both hex outputs are blank.
module tug_referee
  import tug_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SCORE_W   = 3
) (
  input  logic           clk,
  input  logic           reset,
  tug_referee_if.slave   bus,
  output referee_state_t state_o
);

  // Clamp the target so a misconfigured WIN_SCORE still saturates in range.
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int WIN_CLAMP = (WIN_SCORE > SCORE_MAX) ? SCORE_MAX : WIN_SCORE;
  localparam logic [SCORE_W-1:0] WIN_CAP = SCORE_W'(WIN_CLAMP);

  referee_state_t     state_q, state_d;
  logic [SCORE_W-1:0] lscore_q, lscore_d;
  logic [SCORE_W-1:0] rscore_q, rscore_d;
  logic               winner_q, winner_d;
  logic               game_over_q, match_over_q;
  logic               lwin, rwin;

  assign lwin = bus.left_end  & bus.L & ~bus.R;
  assign rwin = bus.right_end & bus.R & ~bus.L;

  always_comb begin
    state_d  = state_q;
    lscore_d = lscore_q;
    rscore_d = rscore_q;
    winner_d = winner_q;
    case (state_q)
      PLAY: begin
        if (lwin) begin
          lscore_d = (lscore_q >= WIN_CAP) ? lscore_q : lscore_q + 1'b1;
          if (lscore_d == WIN_CAP) begin
            state_d  = DONE;
            winner_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end else if (rwin) begin
          rscore_d = (rscore_q >= WIN_CAP) ? rscore_q : rscore_q + 1'b1;
          if (rscore_d == WIN_CAP) begin
            state_d  = DONE;
            winner_d = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD:    state_d = PLAY;
      DONE:    state_d = DONE;
      default: state_d = PLAY;
    endcase
  end

  // game_over/match_over are decoded from the next state so they are
  // registered alongside it rather than glitching off the state bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLAY;
      lscore_q     <= '0;
      rscore_q     <= '0;
      winner_q     <= 1'b0;
      game_over_q  <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lscore_q     <= lscore_d;
      rscore_q     <= rscore_d;
      winner_q     <= winner_d;
      game_over_q  <= (state_d == HOLD) || (state_d == DONE);
      match_over_q <= (state_d == DONE);
    end
  end

  assign bus.game_over   = game_over_q;
  assign bus.match_over  = match_over_q;
  assign bus.winner      = winner_q;
  assign bus.left_score  = lscore_q;
  assign bus.right_score = rscore_q;
  assign state_o         = state_q;

`ifdef TUG_HEX_EN
  seg7_decode u_seg_left (
    .digit_i (4'(lscore_q)),
    .seg_o   (bus.hex_left)
  );
  seg7_decode u_seg_right (
    .digit_i (4'(rscore_q)),
    .seg_o   (bus.hex_right)
  );
`else
  assign bus.hex_left  = SEG_BLANK;
  assign bus.hex_right = SEG_BLANK;
`endif

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee (WIN_SCORE=7, SCORE_W=3), expected values
// hand-computed; hex expectations follow the TUG_HEX_EN build setting.
module tb_tug_referee;
  import tug_pkg::*;

  logic           clk;
  logic           reset;
  referee_state_t state;
  int             n_checks;
  int             n_fails;

`ifdef TUG_HEX_EN
  localparam logic [6:0] HEX_0 = 7'h40;
  localparam logic [6:0] HEX_3 = 7'h30;
`else
  localparam logic [6:0] HEX_0 = 7'h7F;
  localparam logic [6:0] HEX_3 = 7'h7F;
`endif

  tug_referee_if #(.SCORE_W(3)) bus ();

  tug_referee #(.WIN_SCORE(7), .SCORE_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change just after the falling edge, checks happen
  // at the falling edge after the rising edge that consumed them
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic l, input logic r,
                       input logic le, input logic re);
    bus.L = l; bus.R = r; bus.left_end = le; bus.right_end = re;
    cycle();
    bus.L = 1'b0; bus.R = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ls, input int rs,
                         input logic go, input logic mo,
                         input referee_state_t st);
    chk({tag, ".left_score"},  32'(bus.left_score),  32'(ls));
    chk({tag, ".right_score"}, 32'(bus.right_score), 32'(rs));
    chk({tag, ".game_over"},   32'(bus.game_over),   32'(go));
    chk({tag, ".match_over"},  32'(bus.match_over),  32'(mo));
    chk({tag, ".state"},       32'(state),           32'(st));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus.L = 1'b0; bus.R = 1'b0; bus.left_end = 1'b0; bus.right_end = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    // 1: reset state and idle
    chk_all("reset", 0, 0, 1'b0, 1'b0, PLAY);
    chk("reset.winner", 32'(bus.winner), 32'd0);
    repeat (5) cycle();
    chk_all("idle", 0, 0, 1'b0, 1'b0, PLAY);
    chk("idle.hex_left",  32'(bus.hex_left),  32'(HEX_0));
    chk("idle.hex_right", 32'(bus.hex_right), 32'(HEX_0));

    // 2: one left win, HOLD for exactly one cycle, presses ignored in HOLD
    press(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("lwin", 1, 0, 1'b1, 1'b0, HOLD);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("hold_exit", 1, 0, 1'b0, 1'b0, PLAY);

    // 3: simultaneous presses cancel; press at the wrong end does nothing
    press(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("cancel", 1, 0, 1'b0, 1'b0, PLAY);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("wrong_end", 1, 0, 1'b0, 1'b0, PLAY);
    press(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("wrong_end_r", 1, 0, 1'b0, 1'b0, PLAY);

    // 4: seven right wins take the match
    for (int i = 1; i <= 7; i++) begin
      press(1'b0, 1'b1, 1'b0, 1'b1);
      if (i < 7) begin
        chk_all($sformatf("rwin%0d", i), 1, i, 1'b1, 1'b0, HOLD);
        cycle();
      end
    end
    chk_all("match", 1, 7, 1'b1, 1'b1, DONE);
    chk("match.winner", 32'(bus.winner), 32'd1);
    press(1'b0, 1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("frozen", 1, 7, 1'b1, 1'b1, DONE);
    chk("frozen.winner", 32'(bus.winner), 32'd1);

    // 5: reset out of DONE, then reset during HOLD
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_all("rst_done", 0, 0, 1'b0, 1'b0, PLAY);
    chk("rst_done.winner", 32'(bus.winner), 32'd0);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("pre_rst_hold", 1, 0, 1'b1, 1'b0, HOLD);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_all("rst_hold", 0, 0, 1'b0, 1'b0, PLAY);

    // 6: left to 3, check hex outputs for this build
    for (int i = 1; i <= 3; i++) begin
      press(1'b1, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    chk_all("left3", 3, 0, 1'b0, 1'b0, PLAY);
    chk("left3.hex_left",  32'(bus.hex_left),  32'(HEX_3));
    chk("left3.hex_right", 32'(bus.hex_right), 32'(HEX_0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
